// File: rtl/pc_next_if.sv
// Fetch-side control bundle for pc_next_unit: redirect requests in, fetch PC and status out.
// The master is the control/decode side; the slave is the PC unit itself.
interface pc_next_if;
    logic        stall;
    logic        jr;
    logic [31:0] jr_target;
    logic        jump;
    logic [27:0] jump_target28;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        slot_pending;
    logic        addr_err;

    modport master (
        output stall, jr, jr_target, jump, jump_target28, branch_taken, branch_offset,
        input  pc, pc_plus4, slot_pending, addr_err
    );

    modport slave (
        input  stall, jr, jr_target, jump, jump_target28, branch_taken, branch_offset,
        output pc, pc_plus4, slot_pending, addr_err
    );
endinterface

// File: rtl/pc_next_unit.sv
// Program counter and next-PC selection: jr > jump > branch > sequential, with misaligned-jr trap.
// Optional architectural branch delay slot enabled by defining PC_DELAY_SLOT_EN.
module pc_next_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0080
) (
    input  logic       clk,
    input  logic       rst,
    pc_next_if.slave   bus
);

    logic [31:0] pc_q, pc_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] pc_plus4;
    logic [31:0] jump_tgt;
    logic [31:0] branch_tgt;
    logic [31:0] redirect_tgt;
    logic        redirect_req;
    logic        jr_misaligned;

    always_comb begin
        pc_plus4      = pc_q + 32'd4;
        jump_tgt      = {pc_plus4[31:28], bus.jump_target28};
        branch_tgt    = pc_plus4 + bus.branch_offset;
        jr_misaligned = bus.jr && (bus.jr_target[1:0] != 2'b00);
        redirect_req  = bus.jr | bus.jump | bus.branch_taken;

        if (bus.jr) begin
            redirect_tgt = bus.jr_target;
        end else if (bus.jump) begin
            redirect_tgt = jump_tgt;
        end else if (bus.branch_taken) begin
            redirect_tgt = branch_tgt;
        end else begin
            redirect_tgt = pc_plus4;
        end
    end

`ifdef PC_DELAY_SLOT_EN
    logic        slot_q, slot_d;
    logic [31:0] slot_tgt_q, slot_tgt_d;

    // A trapping jr wins even inside a delay slot; any other redirect in the slot is dropped.
    always_comb begin
        pc_d       = pc_q;
        addr_err_d = 1'b0;
        slot_d     = slot_q;
        slot_tgt_d = slot_tgt_q;
        if (!bus.stall) begin
            if (jr_misaligned) begin
                pc_d       = EXC_VECTOR;
                addr_err_d = 1'b1;
                slot_d     = 1'b0;
                slot_tgt_d = 32'h0000_0000;
            end else if (slot_q) begin
                pc_d       = slot_tgt_q;
                slot_d     = 1'b0;
            end else if (redirect_req) begin
                pc_d       = pc_plus4;
                slot_d     = 1'b1;
                slot_tgt_d = redirect_tgt;
            end else begin
                pc_d       = pc_plus4;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q     <= 1'b0;
            slot_tgt_q <= 32'h0000_0000;
        end else begin
            slot_q     <= slot_d;
            slot_tgt_q <= slot_tgt_d;
        end
    end

    assign bus.slot_pending = slot_q;
`else
    always_comb begin
        pc_d       = pc_q;
        addr_err_d = 1'b0;
        if (!bus.stall) begin
            if (jr_misaligned) begin
                pc_d       = EXC_VECTOR;
                addr_err_d = 1'b1;
            end else if (redirect_req) begin
                pc_d       = redirect_tgt;
            end else begin
                pc_d       = pc_plus4;
            end
        end
    end

    assign bus.slot_pending = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            addr_err_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_plus4 = pc_plus4;
    assign bus.addr_err = addr_err_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit with a queue scoreboard; handles both delay-slot builds.
module tb_pc_next_unit;

    logic clk = 1'b0;
    logic rst;
    logic w_rst;

    always #5 clk = ~clk;

    pc_next_if bus ();
    pc_next_if w_bus ();

    pc_next_unit u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    pc_next_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk (clk),
        .rst (w_rst),
        .bus (w_bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic        err;
        logic        slot;
        string       name;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_pc;

    task automatic chk32(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic chk1(input string name, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", name, obs, exp);
        end
    endtask

    task automatic clear_redirects();
        bus.jr            = 1'b0;
        bus.jump          = 1'b0;
        bus.branch_taken  = 1'b0;
        bus.jr_target     = 32'h0;
        bus.jump_target28 = 28'h0;
        bus.branch_offset = 32'h0;
    endtask

    // Push the expectation for the upcoming edge, then pop and compare once the DUT has updated.
    task automatic cyc(input logic [31:0] e_pc, input logic e_err, input logic e_slot, input string name);
        exp_t e;
        e.pc = e_pc; e.err = e_err; e.slot = e_slot; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk32({e.name, ".pc"}, bus.pc, e.pc);
        chk32({e.name, ".pc_plus4"}, bus.pc_plus4, e.pc + 32'd4);
        chk1({e.name, ".addr_err"}, bus.addr_err, e.err);
        chk1({e.name, ".slot_pending"}, bus.slot_pending, e.slot);
        model_pc = e.pc;
        $display("step %-14s pc=%h addr_err=%b slot=%b", e.name, bus.pc, bus.addr_err, bus.slot_pending);
    endtask

    // Redirect inputs already driven; expect the target immediately or after one delay slot.
    task automatic redirect(input logic [31:0] tgt, input string name);
`ifdef PC_DELAY_SLOT_EN
        cyc(model_pc + 32'd4, 1'b0, 1'b1, {name, "_slot"});
        clear_redirects();
        cyc(tgt, 1'b0, 1'b0, name);
`else
        cyc(tgt, 1'b0, 1'b0, name);
        clear_redirects();
`endif
    endtask

    task automatic set_pc(input logic [31:0] addr);
        bus.jr        = 1'b1;
        bus.jr_target = addr;
        redirect(addr, "set_pc");
    endtask

    initial begin
        rst = 1'b1;
        w_rst = 1'b1;
        model_pc = 32'h0;
        clear_redirects();
        bus.stall = 1'b1;
        bus.jump = 1'b1;
        bus.jump_target28 = 28'h123_4560;
        w_bus.stall = 1'b0;
        w_bus.jr = 1'b0;
        w_bus.jr_target = 32'h0;
        w_bus.jump = 1'b0;
        w_bus.jump_target28 = 28'h0;
        w_bus.branch_taken = 1'b0;
        w_bus.branch_offset = 32'h0;

        // Reset overrides stall and redirect
        cyc(32'h0, 1'b0, 1'b0, "reset0");
        cyc(32'h0, 1'b0, 1'b0, "reset1");
        rst = 1'b0;
        bus.stall = 1'b0;
        clear_redirects();
        cyc(32'h4, 1'b0, 1'b0, "seq4");
        cyc(32'h8, 1'b0, 1'b0, "seq8");

        // Jump keeps upper nibble of pc+4
        set_pc(32'h4000_0010);
        bus.jump = 1'b1;
        bus.jump_target28 = 28'h000_0100;
        redirect(32'h4000_0100, "jump");

        // Branch with negative offset, then priority
        set_pc(32'h0000_0020);
        bus.branch_taken = 1'b1;
        bus.branch_offset = 32'hFFFF_FFF0;
        redirect(32'h0000_0014, "branch");
        set_pc(32'h0000_0020);
        bus.branch_taken = 1'b1;
        bus.branch_offset = 32'hFFFF_FFF0;
        bus.jump = 1'b1;
        bus.jump_target28 = 28'h000_0800;
        redirect(32'h0000_0800, "jump_gt_br");
        set_pc(32'h0000_0020);
        bus.branch_taken = 1'b1;
        bus.branch_offset = 32'hFFFF_FFF0;
        bus.jump = 1'b1;
        bus.jump_target28 = 28'h000_0800;
        bus.jr = 1'b1;
        bus.jr_target = 32'h0000_1000;
        redirect(32'h0000_1000, "jr_gt_all");

        // Misaligned jr traps to the exception vector
        set_pc(32'h0000_0040);
        bus.jr = 1'b1;
        bus.jr_target = 32'h0000_1002;
        cyc(32'h0000_0080, 1'b1, 1'b0, "trap");
        clear_redirects();
        cyc(32'h0000_0084, 1'b0, 1'b0, "post_trap");
        cyc(32'h0000_0088, 1'b0, 1'b0, "post_trap2");

        // Stall discards redirects, including a trapping jr
        set_pc(32'h0000_0100);
        bus.stall = 1'b1;
        bus.jump = 1'b1;
        bus.jump_target28 = 28'h000_0200;
        cyc(32'h0000_0100, 1'b0, 1'b0, "stall0");
        cyc(32'h0000_0100, 1'b0, 1'b0, "stall1");
        bus.jr = 1'b1;
        bus.jr_target = 32'h0000_0003;
        cyc(32'h0000_0100, 1'b0, 1'b0, "stall_jrbad");
        bus.stall = 1'b0;
        clear_redirects();
        cyc(32'h0000_0104, 1'b0, 1'b0, "unstall");

`ifdef PC_DELAY_SLOT_EN
        // Stall while a slot target is pending, then redirect ignored in slot
        set_pc(32'h0000_0100);
        bus.jump = 1'b1;
        bus.jump_target28 = 28'h000_0200;
        cyc(32'h0000_0104, 1'b0, 1'b1, "ds_redirect");
        clear_redirects();
        bus.stall = 1'b1;
        cyc(32'h0000_0104, 1'b0, 1'b1, "ds_stall0");
        cyc(32'h0000_0104, 1'b0, 1'b1, "ds_stall1");
        cyc(32'h0000_0104, 1'b0, 1'b1, "ds_stall2");
        bus.stall = 1'b0;
        bus.jump = 1'b1;
        bus.jump_target28 = 28'h000_0400;
        cyc(32'h0000_0200, 1'b0, 1'b0, "ds_taken");
        clear_redirects();
        cyc(32'h0000_0204, 1'b0, 1'b0, "ds_after");

        // Misaligned jr inside the slot still traps and drops the pending target
        bus.branch_taken = 1'b1;
        bus.branch_offset = 32'h0000_0100;
        cyc(32'h0000_0208, 1'b0, 1'b1, "ds_br");
        clear_redirects();
        bus.jr = 1'b1;
        bus.jr_target = 32'h0000_0301;
        cyc(32'h0000_0080, 1'b1, 1'b0, "ds_trap");
        clear_redirects();
        cyc(32'h0000_0084, 1'b0, 1'b0, "ds_trap_after");

        // Reset mid-slot discards the pending target
        bus.jump = 1'b1;
        bus.jump_target28 = 28'h000_0700;
        cyc(32'h0000_0088, 1'b0, 1'b1, "ds_pre_rst");
        clear_redirects();
        rst = 1'b1;
        cyc(32'h0000_0000, 1'b0, 1'b0, "ds_rst");
        rst = 1'b0;
        cyc(32'h0000_0004, 1'b0, 1'b0, "ds_rst_after");
`else
        // Reset while a redirect is presented
        bus.jump = 1'b1;
        bus.jump_target28 = 28'h000_0700;
        rst = 1'b1;
        cyc(32'h0000_0000, 1'b0, 1'b0, "rst_redirect");
        rst = 1'b0;
        clear_redirects();
        cyc(32'h0000_0004, 1'b0, 1'b0, "rst_after");
`endif

        // Wrap-around from the top of the address space
        chk32("wrap.reset_pc", w_bus.pc, 32'hFFFF_FFFC);
        chk32("wrap.pc_plus4", w_bus.pc_plus4, 32'h0000_0000);
        w_rst = 1'b0;
        @(posedge clk);
        #1;
        chk32("wrap.next_pc", w_bus.pc, 32'h0000_0000);
        chk32("wrap.next_plus4", w_bus.pc_plus4, 32'h0000_0004);
        $display("step %-14s pc=%h", "wrap", w_bus.pc);

        chk32("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_next_unit.md
# pc_next_unit

Program-counter register and next-PC selection for the MIPS datapath. Consumes the 28-bit word-aligned jump field produced by the jump-target shift stage, plus branch and register-jump requests, and forms the 32-bit fetch address each cycle. Sits directly downstream of the jump-field shifter and upstream of instruction memory. It also supports stall hold, misaligned-target trapping and an optional architectural branch delay slot.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- EXC_VECTOR, 32'h0000_0080, PC loaded on a misaligned register-jump target
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- stall  input  1  hold PC and all internal state; redirect inputs ignored
- jr  input  1  register jump for the instruction at `pc`
- jr_target  input  32  register-jump target
- jump  input  1  J/JAL for the instruction at `pc`
- jump_target28  input  28  shifted jump field ({instr_index, 2'b00})
- branch_taken  input  1  resolved taken branch for the instruction at `pc`
- branch_offset  input  32  sign-extended word offset, already shifted left 2
- pc  output  32  current fetch address (registered)
- pc_plus4  output  32  pc + 4, combinational, modulo 2^32
- slot_pending  output  1  delay-slot redirect stored (always 0 without macro)
- addr_err  output  1  one-cycle registered pulse: misaligned jr target trapped

## Operation
- Redirect inputs describe the instruction currently addressed by `pc`.
- Target formation: jump → {pc_plus4[31:28], jump_target28}; branch → pc_plus4 + branch_offset (32-bit wrap, carry discarded); jr → jr_target.
- Priority when several asserted: jr > jump > branch_taken > sequential (pc_plus4).
- jr with jr_target[1:0] != 0: no redirect; next pc = EXC_VECTOR; addr_err = 1 next cycle; any pending delay-slot target cleared.
- jump and branch targets are aligned by construction; no check.
- stall = 1: pc, pending state and addr_err hold (addr_err forced 0 during stall cycles); redirects in the same cycle are discarded (the held instruction re-presents them).
- Reset: pc = RESET_PC, slot_pending = 0, addr_err = 0, pending target = 0. Reset overrides stall and all redirects.

## Timing
- Selected next PC appears on `pc` one cycle after the redirect cycle (zero-bubble, no delay slot build).
- pc_plus4 tracks `pc` combinationally in the same cycle.
- addr_err asserted exactly one cycle, coincident with pc = EXC_VECTOR.
- Wrap-around: pc = 32'hFFFF_FFFC, no redirect → next pc = 32'h0000_0000.
- Reset asserted mid-delay-slot: pending discarded, pc = RESET_PC next cycle.

## Configuration
- Macro PC_DELAY_SLOT_EN.
- Defined: a non-trapping redirect (jr/jump/branch) stores its target and sets slot_pending; next pc = pc_plus4 (delay slot). On the next non-stalled cycle pc loads the stored target and slot_pending clears. Redirect inputs while slot_pending = 1 are ignored (redirect in a delay slot is not honoured); a misaligned jr in the slot still traps. Stall while pending holds everything.
- Undefined: redirects take effect immediately; slot_pending tied 0; no pending register.

## Test plan
- Reset: rst=1 with stall=1, jump=1 → pc=32'h0000_0000, slot_pending=0, addr_err=0; after release pc increments 0→4→8.
- Jump: pc=32'h4000_0010, jump=1, jump_target28=28'h000_0100 → next pc=32'h4000_0100 (macro off); macro on: 32'h4000_0014 then 32'h4000_0100, slot_pending high one cycle.
- Branch and priority: pc=32'h0000_0020, branch_taken=1, branch_offset=32'hFFFF_FFF0 → 32'h0000_0014; same cycle jump=1 target 28'h000_0800 → 32'h0000_0800; add jr=1, jr_target=32'h0000_1000 → 32'h0000_1000.
- Misaligned jr: pc=32'h0000_0040, jr=1, jr_target=32'h0000_1002 → pc=32'h0000_0080, addr_err=1 one cycle then 0, pc→32'h0000_0084.
- Stall: pc=32'h0000_0100, stall=1 three cycles with jump=1 → pc stays 32'h0000_0100; macro on with slot_pending=1 during stall → target taken on first unstalled cycle.
- Wrap: force pc to 32'hFFFF_FFFC (via RESET_PC) → pc_plus4=0, next pc=0.
